// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read port, burst control and downstream valid/ready bundle
interface fifo_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  start;
  logic [CNT_WIDTH-1:0]  len;
  logic                  abort;
  logic [CNT_WIDTH-1:0]  data_count;
  logic                  rd_ack;
  logic                  rd_err;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  err_count;
  logic [2:0]            state;
  modport master (
    input  start, len, abort, data_count, rd_ack, rd_err, d_out, m_ready,
    output rd_en, m_valid, m_data, busy, done, err_count, state
  );
  modport slave (
    output start, len, abort, data_count, rd_ack, rd_err, d_out, m_ready,
    input  rd_en, m_valid, m_data, busy, done, err_count, state
  );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: burst read master that drains a FIFO word by word into a valid/ready sink
module fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
) (
  input logic clk,
  input logic reset,
  fifo_reader_if.master bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    REQ   = 3'b001,
    ISSUE = 3'b010,
    WAIT  = 3'b011,
    HOLD  = 3'b100,
    DONE  = 3'b101
  } state_t;
  state_t st, nx;
  logic [CNT_WIDTH-1:0]  rem;
  logic [CNT_WIDTH-1:0]  errs;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  ack_ok;
  assign ack_ok = bus.rd_ack && !bus.rd_err;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= IDLE;
    else st <= nx;
  // next state; abort overrides everything, unused codes fall back to IDLE
  always_comb begin
    nx = IDLE;
    case (st)
      IDLE:    nx = !bus.start ? IDLE : (bus.len != '0) ? REQ : DONE;
      REQ:     nx = (bus.data_count != '0) ? ISSUE : REQ;
      ISSUE:   nx = WAIT;
      WAIT:    nx = ack_ok ? HOLD : REQ;
      HOLD:    nx = !bus.m_ready ? HOLD : (rem == CNT_WIDTH'(1)) ? DONE : REQ;
      DONE:    nx = IDLE;
      default: nx = IDLE;
    endcase
    if (bus.abort) nx = IDLE;
  end
  // words left, captured data and saturating error count
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem    <= '0;
      errs   <= '0;
      data_q <= '0;
    end else begin
      if (bus.abort) rem <= '0;
      else if (st == IDLE && bus.start) rem <= bus.len;
      else if (st == HOLD && bus.m_ready) rem <= rem - CNT_WIDTH'(1);
      if (!bus.abort && st == WAIT) begin
        if (ack_ok) data_q <= bus.d_out;
        else if (errs != '1) errs <= errs + CNT_WIDTH'(1);
      end
    end
  assign bus.rd_en     = (st == ISSUE);
  assign bus.m_valid   = (st == HOLD);
  assign bus.m_data    = data_q;
  assign bus.busy      = (st != IDLE);
  assign bus.done      = (st == DONE);
  assign bus.err_count = errs;
  assign bus.state     = st;
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bursts against a FIFO model with a scoreboard on the downstream port
module tb_fifo_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_reader_if #(.DATA_WIDTH(32), .CNT_WIDTH(4)) bus ();
  fifo_reader #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int rise_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, rden_cnt = 0;
  int force_err = 0, err_both = 0;
  logic pend = 1'b0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // FIFO model: answers a read one cycle after rd_en, optionally with forced errors
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      bus.rd_ack = 1'b0;
      bus.rd_err = 1'b0;
      bus.d_out = '0;
    end else begin
      bus.rd_ack = 1'b0;
      bus.rd_err = 1'b0;
      if (pend) begin
        if (err_both > 0) begin
          err_both--;
          bus.rd_ack = 1'b1;
          bus.rd_err = 1'b1;
          bus.d_out = 32'hBAD0BAD0;
        end else if (force_err > 0 || fq.size() == 0) begin
          if (force_err > 0) force_err--;
          bus.rd_err = 1'b1;
        end else begin
          bus.rd_ack = 1'b1;
          bus.d_out = fq.pop_front();
        end
      end
      pend = bus.rd_en;
    end
    bus.data_count = 4'(fq.size());
  end
  // monitor: counts strobes/pulses and scores every downstream handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) done_cnt++;
      if (bus.rd_en) begin
        rden_cnt++;
        rise_q.push_back(cyc);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected no word", bus.m_data);
        end else check("m_data", bus.m_data, exp_q.pop_front());
      end
    end
  end
  task automatic start_burst(input logic [3:0] l);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len = l;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_st(input logic [2:0] s, input int budget, input string nm);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.state !== s && i < budget);
    check(nm, 32'(bus.state), 32'(s));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, r0;
    logic [31:0] hold_data;
    bus.start = 1'b0;
    bus.len = '0;
    bus.abort = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(bus.state), 0);
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err_count), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    // basic burst of three
    foreach (fq[i]) fq.delete(i);
    fq = '{32'h11, 32'h22, 32'h33};
    exp_q = '{32'h11, 32'h22, 32'h33};
    rise_q.delete();
    d0 = done_cnt; r0 = rden_cnt;
    start_burst(4'd3);
    wait_st(3'b000, 60, "t1_end");
    check("t1_done", 32'(done_cnt - d0), 1);
    check("t1_rden", 32'(rden_cnt - r0), 3);
    if (rise_q.size() >= 3) begin
      check("t1_gap0", 32'(rise_q[1] - rise_q[0]), 4);
      check("t1_gap1", 32'(rise_q[2] - rise_q[1]), 4);
    end else check("t1_rises", 32'(rise_q.size()), 3);
    check("t1_err", 32'(bus.err_count), 0);
    check("t1_left", 32'(exp_q.size()), 0);
    // empty FIFO: must park in REQ without strobing
    d0 = done_cnt;
    start_burst(4'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t2_state", 32'(bus.state), 1);
      check("t2_rd_en", 32'(bus.rd_en), 0);
    end
    check("t2_busy", 32'(bus.busy), 1);
    @(posedge clk); #1;
    fq.push_back(32'hA5); fq.push_back(32'h5A);
    exp_q.push_back(32'hA5); exp_q.push_back(32'h5A);
    wait_st(3'b000, 60, "t2_end");
    check("t2_done", 32'(done_cnt - d0), 1);
    check("t2_left", 32'(exp_q.size()), 0);
    // back-pressure
    bus.m_ready = 1'b0;
    fq.push_back(32'h77); exp_q.push_back(32'h77);
    d0 = done_cnt;
    start_burst(4'd1);
    wait_st(3'b100, 40, "t3_hold");
    hold_data = bus.m_data;
    check("t3_first", hold_data, 32'h77);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_valid", 32'(bus.m_valid), 1);
      check("t3_data", bus.m_data, 32'h77);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_st(3'b000, 10, "t3_end");
    check("t3_done", 32'(done_cnt - d0), 1);
    check("t3_left", 32'(exp_q.size()), 0);
    // errors: one ack+err together, one plain error, then the word
    err_both = 1; force_err = 1;
    fq.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
    start_burst(4'd1);
    wait_st(3'b000, 60, "t4_end");
    check("t4_err", 32'(bus.err_count), 2);
    check("t4_data", bus.m_data, 32'hDEADBEEF);
    check("t4_left", 32'(exp_q.size()), 0);
    force_err = 17;
    fq.push_back(32'h99); exp_q.push_back(32'h99);
    start_burst(4'd1);
    wait_st(3'b000, 200, "t4_sat_end");
    check("t4_sat", 32'(bus.err_count), 15);
    check("t4_sat_data", bus.m_data, 32'h99);
    // abort while holding a word
    bus.m_ready = 1'b0;
    fq.push_back(32'h55);
    d0 = done_cnt;
    start_burst(4'd2);
    wait_st(3'b100, 40, "t5_hold");
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check("t5_state", 32'(bus.state), 0);
    check("t5_valid", 32'(bus.m_valid), 0);
    repeat (3) @(negedge clk);
    check("t5_nodone", 32'(done_cnt - d0), 0);
    check("t5_err_kept", 32'(bus.err_count), 15);
    // asynchronous reset while rd_en is high
    bus.m_ready = 1'b1;
    fq.push_back(32'h66);
    start_burst(4'd1);
    wait_st(3'b010, 20, "t5_issue");
    reset = 1'b1;
    #1;
    check("t5_rst_rd_en", 32'(bus.rd_en), 0);
    check("t5_rst_state", 32'(bus.state), 0);
    check("t5_rst_err", 32'(bus.err_count), 0);
    check("t5_rst_data", bus.m_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    fq.delete();
    // zero length
    r0 = rden_cnt; d0 = done_cnt;
    start_burst(4'd0);
    @(negedge clk);
    check("t6_state_done", 32'(bus.state), 5);
    check("t6_done", 32'(bus.done), 1);
    @(negedge clk);
    check("t6_state_idle", 32'(bus.state), 0);
    check("t6_done_low", 32'(bus.done), 0);
    repeat (3) @(negedge clk);
    check("t6_rden", 32'(rden_cnt - r0), 0);
    check("t6_pulses", 32'(done_cnt - d0), 1);
    check("final_left", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side master for the team's 8-deep, 32-bit FIFO.
- Accepts a burst request of N words and issues single-cycle rd_en pulses, only when the FIFO reports data (data_count > 0).
- Captures each returned word on rd_ack and presents it to a downstream valid/ready sink.
- Counts rd_err responses, so FIFO read-error behaviour can be exercised and checked from the consumer side.

Parameters:
- DATA_WIDTH, 32, width of FIFO data and m_data.
- CNT_WIDTH, 4, width of data_count, len, remaining and err_count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle burst request; sampled in IDLE only.
- len  in  CNT_WIDTH  number of words to read; latched on start.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- data_count  in  CNT_WIDTH  FIFO occupancy, 0..8.
- rd_ack  in  1  FIFO read acknowledge; valid the cycle after rd_en.
- rd_err  in  1  FIFO read error (read on empty); valid the cycle after rd_en.
- d_out  in  DATA_WIDTH  FIFO read data; valid with rd_ack.
- rd_en  out  1  FIFO read strobe.
- m_valid  out  1  downstream data valid.
- m_data  out  DATA_WIDTH  downstream data.
- m_ready  in  1  downstream ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on burst completion.
- err_count  out  CNT_WIDTH  saturating count of read errors.
- state  out  3  current state, for debug and bench checking.

Behaviour:
- State encoding: IDLE=000, REQ=001, ISSUE=010, WAIT=011, HOLD=100, DONE=101. Codes 110 and 111 go to IDLE on the next clock.
- Reset values: state=IDLE, rd_en=0, m_valid=0, m_data=0, done=0, err_count=0, remaining=0.
- All outputs are Moore, decoded from registered state/datapath; none depends combinationally on inputs.
- IDLE:
  - start=1 and len>0: latch remaining=len, go to REQ.
  - start=1 and len=0: go to DONE; no rd_en is issued.
  - start=0: stay in IDLE.
- REQ:
  - data_count>0: go to ISSUE.
  - data_count=0: stay in REQ, rd_en=0. The block never issues a read while it sees the FIFO empty, and waits indefinitely.
- ISSUE: rd_en=1 for exactly this one cycle, then go to WAIT unconditionally.
- WAIT (the cycle after the rd_en pulse):
  - rd_ack=1: m_data<=d_out, m_valid<=1, go to HOLD.
  - Otherwise (rd_err=1, neither asserted, or both asserted): err_count+1 saturating at all-ones, remaining unchanged, go to REQ to retry.
  - rd_ack and rd_err both asserted: treated as error; data is discarded.
- HOLD:
  - m_valid=1 and m_data is held stable until m_ready=1.
  - On the handshake cycle: m_valid<=0 and remaining<=remaining-1.
  - remaining=1 at the handshake: go to DONE.
  - Otherwise: go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- Per-word latency:
  - The minimum is 4 cycles from entering REQ to m_valid rising (REQ, ISSUE, WAIT, HOLD-entry edge).
  - Peak throughput is 1 word per 4 cycles when m_ready=1 and the FIFO is non-empty.
- Abort:
  - abort=1 in any state returns to IDLE on the next edge.
  - It clears m_valid, rd_en and remaining.
  - done is not pulsed; err_count is retained.
  - abort in ISSUE still lets the current rd_en cycle complete. The response the FIFO returns next cycle is ignored, and the word is lost by design.
- start while busy is ignored. len is not re-sampled mid-burst.
- err_count is cleared only by reset.
- len greater than 8 is legal. The block refills from the FIFO as data arrives.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously), including a rd_en that is currently asserted.

Test Plan:
1. Basic burst: FIFO preloaded with 0x11,0x22,0x33 (data_count=3), start with len=3, m_ready=1 -> three rd_en pulses, each 4 cycles apart; m_data sequence 0x11,0x22,0x33; done pulses once; err_count=0; state returns to 000.
2. Empty wait: data_count=0, start with len=2 -> state held at 001 with rd_en=0 for 20 cycles. Then push 0xA5 and 0x5A -> both words delivered, done=1.
3. Back-pressure: len=1, m_ready=0 for 10 cycles after m_valid rises -> m_valid and m_data stay constant for all 10 cycles; on m_ready=1 there is one handshake, then DONE.
4. Read error: model drives rd_err=1 in WAIT twice, then rd_ack with 0xDEADBEEF -> err_count=2 and m_data=0xDEADBEEF. Then 17 forced errors -> err_count saturates at 15.
5. Abort and reset: abort asserted in HOLD -> m_valid=0 and state=000 next edge, no done pulse. Reset asserted mid-ISSUE -> rd_en drops before the next clock edge.
6. Zero length: start with len=0 -> state goes to DONE, done pulses one cycle, no rd_en is ever asserted.
